// File: rtl/k005297_prim_pkg.sv
// Shared encodings for the bit-serial primitives: operation modes and FSM states.
package k005297_prim_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_INC  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // SUB and INC start with a carry-in of one (two's complement / +1).
    function automatic logic init_carry(input logic [1:0] mode);
        return (mode == MODE_SUB) || (mode == MODE_INC);
    endfunction

endpackage

// File: rtl/serial_addsub_fa.sv
// Single-bit full adder primitive used as the serial bit slice.
module serial_addsub_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one operand bit per clock-enable tick, LSB first,
// with a parallel result register updated on the final bit.
module serial_addsub
    import k005297_prim_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          i_CLK,
    input  logic          i_RST_n,
    input  logic          i_CEN_n,
    input  logic          i_CLR,
    input  logic          i_START,
    input  logic [1:0]    i_MODE,
    input  logic          i_A,
    input  logic          i_B,
    output logic          o_S,
    output logic          o_BUSY,
    output logic          o_DONE,
    output logic          o_COUT,
    output logic [DW-1:0] o_SUM,
    output logic          o_ZERO
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [1:0]    mode;
    // Holds the DW-1 bits already produced; the final bit is merged in directly.
    logic [DW-2:0] shreg;

    logic          tick;
    logic          last;
    logic          b_eff;
    logic          c_in;
    logic          s;
    logic          c_out;
    logic [DW-1:0] next_sum;

    assign tick     = ~i_CEN_n;
    assign last     = (cnt == CW'(DW - 1));
    assign next_sum = {s, shreg};

    always_comb begin
        b_eff = 1'b0;
        c_in  = carry;
        unique case (mode)
            MODE_ADD:  b_eff = i_B;
            MODE_SUB:  b_eff = ~i_B;
            MODE_INC:  b_eff = 1'b0;
            MODE_PASS: c_in  = 1'b0;
            default:   b_eff = 1'b0;
        endcase
    end

    serial_addsub_fa u_fa (
        .a    (i_A),
        .b    (b_eff),
        .cin  (c_in),
        .s    (s),
        .cout (c_out)
    );

    assign o_S    = (state == ST_RUN) ? s : 1'b0;
    assign o_BUSY = (state == ST_RUN);

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            mode   <= MODE_ADD;
            shreg  <= '0;
            o_DONE <= 1'b0;
            o_COUT <= 1'b0;
            o_SUM  <= '0;
            o_ZERO <= 1'b1;
        end else if (tick) begin
            o_DONE <= 1'b0;
            if (i_CLR) begin
                state <= ST_IDLE;
                cnt   <= '0;
                carry <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (i_START) begin
                            state <= ST_RUN;
                            cnt   <= '0;
                            mode  <= i_MODE;
                            carry <= init_carry(i_MODE);
                        end
                    end
                    ST_RUN: begin
                        carry <= c_out;
                        shreg <= next_sum[DW-1:1];
                        cnt   <= cnt + 1'b1;
                        if (last) begin
                            o_SUM  <= next_sum;
                            o_COUT <= c_out;
                            o_ZERO <= (next_sum == '0);
                            o_DONE <= 1'b1;
                            // A START on the final tick chains straight into the next word.
                            if (i_START) begin
                                state <= ST_RUN;
                                cnt   <= '0;
                                mode  <= i_MODE;
                                carry <= init_carry(i_MODE);
                            end else begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
